alu_mp_seq: RTL and testbench

- Multi-precision sequencer for the shared combinational WIDTH-bit ALU.
- Takes operands up to WORDS*WIDTH bits and a 3-bit ALU opcode, then drives the ALU one word per cycle.
- Chains carry/borrow between words for add/subtract, patches inter-word bits for arithmetic shift right, and aggregates flags.
- Sits between the microcode control unit and the ALU; the ALU stays outside this block.

---
 rtl/alu_mp_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_mp_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// alu_mp_seq: multi-precision sequencer for a shared WIDTH-bit ALU.
// It steps an external combinational ALU through up to WORDS words, one per
// cycle, chaining carry/borrow, patching arithmetic-shift-right word MSBs
// and folding the per-word zero flags into one aggregate ZERO flag.
// Optional feature macro: ALU_MP_SEQ_ABORT_EN (adds an 'abort' input).
//
// Handshake: start is sampled only in IDLE; busy is high for the L RUN cycles;
// done pulses for exactly one cycle after the last word. There is no
// back-pressure, and a start outside IDLE is dropped, not queued.

`ifndef ALUCTLW
`define ALUCTLW 3
`endif
`ifndef FWIDTH
`define FWIDTH 4
`endif
`ifndef ALU_FLAG_CARRY
`define ALU_FLAG_CARRY 0
`endif
`ifndef ALU_FLAG_ZERO
`define ALU_FLAG_ZERO 1
`endif
`ifndef ALU_FLAG_SIGN
`define ALU_FLAG_SIGN 2
`endif
`ifndef ALU_FLAG_OVF
`define ALU_FLAG_OVF 3
`endif

module alu_mp_seq #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef ALU_MP_SEQ_ABORT_EN
    input  logic                      abort,
`endif
    input  logic [`ALUCTLW-1:0]       op,
    input  logic [$clog2(WORDS):0]    len,
    input  logic                      cin,
    input  logic [WORDS*WIDTH-1:0]    a,
    input  logic [WORDS*WIDTH-1:0]    b,
    output logic                      busy,
    output logic                      done,
    output logic [WORDS*WIDTH-1:0]    result,
    output logic [`FWIDTH-1:0]        flags,
    output logic [WIDTH-1:0]          alu_op1,
    output logic [WIDTH-1:0]          alu_op2,
    output logic [`ALUCTLW-1:0]       alu_ctl,
    output logic [`FWIDTH-1:0]        alu_flags_in,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic [`FWIDTH-1:0]        alu_flags,
    output logic [1:0]                state_dbg
);

    localparam int KW = $clog2(WORDS);
    localparam int LW = KW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WORDS*WIDTH-1:0]  a_q, b_q, result_q;
    logic [`ALUCTLW-1:0]     op_q;
    logic [KW-1:0]           k_q, rem_q;
    logic                    carry_q, first_q, z_q;
    logic [`FWIDTH-1:0]      flags_q;

    logic [LW-1:0]           len_eff, len_m1;
    logic [KW-1:0]           top_k;
    logic                    is_sra, last;
    logic                    abort_hit;
    logic [WIDTH-1:0]        word_out;
    logic [`FWIDTH-1:0]      flags_final;

`ifdef ALU_MP_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Effective word count: 0 means one word, oversize requests clamp to WORDS.
    always_comb begin
        len_eff = len;
        if (len == '0)
            len_eff = LW'(1);
        else if (len > LW'(WORDS))
            len_eff = LW'(WORDS);
        len_m1 = len_eff - LW'(1);
        top_k  = len_m1[KW-1:0];
    end

    // ALU drive and per-word result patching, all from registered state.
    always_comb begin
        is_sra       = (op_q == OP_SRA);
        last         = (rem_q == '0);
        alu_op1      = a_q[k_q*WIDTH +: WIDTH];
        alu_op2      = b_q[k_q*WIDTH +: WIDTH];
        alu_ctl      = op_q;
        alu_flags_in = '0;
        alu_flags_in[`ALU_FLAG_CARRY] = carry_q;
        // Plain add/sub only seed the first word; later words chain the carry.
        if ((op_q == OP_ADD || op_q == OP_SUB) && !first_q)
            alu_ctl = op_q | 3'b001;
        word_out = alu_result;
        // Below the top word, the shifted-in MSB is the higher word's bit 0.
        if (is_sra && !first_q)
            word_out[WIDTH-1] = carry_q;
        flags_final = alu_flags;
        flags_final[`ALU_FLAG_ZERO] = z_q & (word_out == '0);
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort_hit)
                    state_d = S_IDLE;
                else if (last)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus operand latch, word stepping and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            k_q      <= '0;
            rem_q    <= '0;
            carry_q  <= 1'b0;
            first_q  <= 1'b0;
            z_q      <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        carry_q  <= (op == OP_ADC || op == OP_SBC) ? cin : 1'b0;
                        first_q  <= 1'b1;
                        z_q      <= 1'b1;
                        k_q      <= (op == OP_SRA) ? top_k : '0;
                        rem_q    <= top_k;
                        result_q <= '0;
                    end
                end
                S_RUN: begin
                    if (abort_hit) begin
                        a_q      <= '0;
                        b_q      <= '0;
                        op_q     <= '0;
                        k_q      <= '0;
                        rem_q    <= '0;
                        carry_q  <= 1'b0;
                        first_q  <= 1'b0;
                        z_q      <= 1'b0;
                        result_q <= '0;
                        flags_q  <= '0;
                    end else begin
                        result_q[k_q*WIDTH +: WIDTH] <= word_out;
                        carry_q <= alu_flags[`ALU_FLAG_CARRY];
                        first_q <= 1'b0;
                        z_q     <= z_q & (word_out == '0);
                        k_q     <= is_sra ? k_q - KW'(1) : k_q + KW'(1);
                        rem_q   <= rem_q - KW'(1);
                        if (last)
                            flags_q <= flags_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
// tb_alu_mp_seq: directed-vector bench for alu_mp_seq with a behavioural
// 8-bit ALU model attached to the ALU-side ports. Flag layout {V,N,Z,C}.

`ifndef ALUCTLW
`define ALUCTLW 3
`endif
`ifndef FWIDTH
`define FWIDTH 4
`endif
`ifndef ALU_FLAG_CARRY
`define ALU_FLAG_CARRY 0
`endif
`ifndef ALU_FLAG_ZERO
`define ALU_FLAG_ZERO 1
`endif
`ifndef ALU_FLAG_SIGN
`define ALU_FLAG_SIGN 2
`endif
`ifndef ALU_FLAG_OVF
`define ALU_FLAG_OVF 3
`endif

module tb_alu_mp_seq;
    localparam int WIDTH = 8;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = '0;
    logic [2:0]  len = '0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [7:0]  alu_op1, alu_op2, alu_result;
    logic [2:0]  alu_ctl;
    logic [3:0]  alu_flags_in, alu_flags;
    logic [1:0]  state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  ctl_log [0:15];

    alu_mp_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ALU_MP_SEQ_ABORT_EN
        .abort(abort),
`endif
        .op(op), .len(len), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctl(alu_ctl),
        .alu_flags_in(alu_flags_in), .alu_result(alu_result),
        .alu_flags(alu_flags), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural ALU: subtract is op2 - op1, carry=1 means borrow.
    logic [8:0] alu_t;
    logic       alu_v;
    logic       alu_ci;
    always_comb begin
        alu_t  = '0;
        alu_v  = 1'b0;
        alu_ci = alu_flags_in[`ALU_FLAG_CARRY];
        case (alu_ctl)
            3'd0: begin alu_t = {1'b0, alu_op1} + {1'b0, alu_op2};
                  alu_v = (alu_op1[7] == alu_op2[7]) && (alu_t[7] != alu_op1[7]); end
            3'd1: begin alu_t = {1'b0, alu_op1} + {1'b0, alu_op2} + {8'd0, alu_ci};
                  alu_v = (alu_op1[7] == alu_op2[7]) && (alu_t[7] != alu_op1[7]); end
            3'd2: begin alu_t = {1'b0, alu_op2} - {1'b0, alu_op1};
                  alu_v = (alu_op2[7] != alu_op1[7]) && (alu_t[7] != alu_op2[7]); end
            3'd3: begin alu_t = {1'b0, alu_op2} - {1'b0, alu_op1} - {8'd0, alu_ci};
                  alu_v = (alu_op2[7] != alu_op1[7]) && (alu_t[7] != alu_op2[7]); end
            3'd4: alu_t = {1'b0, alu_op1 & alu_op2};
            3'd5: alu_t = {1'b0, alu_op1 | alu_op2};
            3'd6: alu_t = {1'b0, alu_op1 ^ alu_op2};
            default: alu_t = {alu_op1[0], alu_op1[7], alu_op1[7:1]};
        endcase
        alu_result = alu_t[7:0];
        alu_flags  = '0;
        alu_flags[`ALU_FLAG_CARRY] = alu_t[8];
        alu_flags[`ALU_FLAG_ZERO]  = (alu_t[7:0] == 8'd0);
        alu_flags[`ALU_FLAG_SIGN]  = alu_t[7];
        alu_flags[`ALU_FLAG_OVF]   = alu_v;
    end

    // Driver: one start pulse, then scramble inputs and wait (bounded) for done.
    task automatic drive_op(input logic [2:0] t_op, input logic [2:0] t_len,
                            input logic t_cin, input logic [31:0] t_a,
                            input logic [31:0] t_b, output int done_cyc,
                            output logic [15:0] busy_mask);
        @(negedge clk);
        op = t_op; len = t_len; cin = t_cin; a = t_a; b = t_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op  = 3'($urandom_range(7, 0));
        len = 3'($urandom_range(7, 0));
        cin = 1'($urandom_range(1, 0));
        a   = $urandom;
        b   = $urandom;
        done_cyc  = -1;
        busy_mask = '0;
        for (int c = 1; c <= 15; c++) begin
            busy_mask[c] = busy;
            ctl_log[c]   = alu_ctl;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int dc; logic [15:0] bm;
        drive_op(3'b000, 3'd2, 1'b1, 32'h0000_00FF, 32'h0000_0001, dc, bm);
        checks++; if (dc !== 3) begin errors++; $display("FAIL add_done_cycle got %0d exp 3", dc); end
        checks++; if (bm !== 16'h0006) begin errors++; $display("FAIL add_busy_cycles got %h exp 0006", bm); end
        checks++; if (result !== 32'h0000_0100) begin errors++; $display("FAIL add_result got %h exp 00000100", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL add_flags got %b exp 0000", flags); end
        checks++; if (ctl_log[1] !== 3'b000) begin errors++; $display("FAIL add_ctl_w0 got %b exp 000", ctl_log[1]); end
        checks++; if (ctl_log[2] !== 3'b001) begin errors++; $display("FAIL add_ctl_w1 got %b exp 001", ctl_log[2]); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_one_cycle got %0b exp 0", done); end
        checks++; if (result !== 32'h0000_0100) begin errors++; $display("FAIL add_result_hold got %h exp 00000100", result); end
    endtask

    task automatic test_sub();
        int dc; logic [15:0] bm;
        drive_op(3'b010, 3'd2, 1'b0, 32'h0000_0002, 32'h0000_0001, dc, bm);
        checks++; if (dc !== 3) begin errors++; $display("FAIL sub_done_cycle got %0d exp 3", dc); end
        checks++; if (result !== 32'h0000_FFFF) begin errors++; $display("FAIL sub_result got %h exp 0000ffff", result); end
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL sub_flags got %b exp 0101", flags); end
        checks++; if (ctl_log[2] !== 3'b011) begin errors++; $display("FAIL sub_ctl_w1 got %b exp 011", ctl_log[2]); end
    endtask

    task automatic test_sbc();
        int dc; logic [15:0] bm;
        drive_op(3'b011, 3'd2, 1'b1, 32'h0000_0001, 32'h0000_0101, dc, bm);
        checks++; if (result !== 32'h0000_00FF) begin errors++; $display("FAIL sbc_result got %h exp 000000ff", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL sbc_flags got %b exp 0000", flags); end
    endtask

    task automatic test_sra();
        int dc; logic [15:0] bm;
        drive_op(3'b111, 3'd4, 1'b0, 32'h8000_0001, 32'h0, dc, bm);
        checks++; if (dc !== 5) begin errors++; $display("FAIL sra_done_cycle got %0d exp 5", dc); end
        checks++; if (result !== 32'hC000_0000) begin errors++; $display("FAIL sra_result got %h exp c0000000", result); end
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL sra_flags got %b exp 0001", flags); end
        checks++; if (ctl_log[3] !== 3'b111) begin errors++; $display("FAIL sra_ctl got %b exp 111", ctl_log[3]); end
    endtask

    task automatic test_partial_len();
        int dc; logic [15:0] bm;
        drive_op(3'b000, 3'd3, 1'b0, 32'h1111_1111, 32'h2222_2222, dc, bm);
        checks++; if (dc !== 4) begin errors++; $display("FAIL len3_done_cycle got %0d exp 4", dc); end
        checks++; if (result !== 32'h0033_3333) begin errors++; $display("FAIL len3_result got %h exp 00333333", result); end
    endtask

    task automatic test_xor_and_len0();
        int dc; logic [15:0] bm;
        drive_op(3'b110, 3'd4, 1'b0, 32'h1234_5678, 32'h1234_5678, dc, bm);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL xor_result got %h exp 00000000", result); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL xor_flags got %b exp 0010", flags); end
        drive_op(3'b110, 3'd0, 1'b0, 32'h0000_0001, 32'h0000_0003, dc, bm);
        checks++; if (dc !== 2) begin errors++; $display("FAIL len0_done_cycle got %0d exp 2", dc); end
        checks++; if (result !== 32'h0000_0002) begin errors++; $display("FAIL len0_result got %h exp 00000002", result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL len0_flags got %b exp 0000", flags); end
    endtask

    task automatic test_len_clamp();
        int dc; logic [15:0] bm;
        drive_op(3'b000, 3'd7, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, dc, bm);
        checks++; if (dc !== 5) begin errors++; $display("FAIL clamp_done_cycle got %0d exp 5", dc); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL clamp_result got %h exp 00000000", result); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL clamp_flags got %b exp 0011", flags); end
    endtask

    task automatic test_start_ignored();
        int dc;
        @(negedge clk);
        op = 3'b110; len = 3'd4; a = 32'h0F0F_0F0F; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 3'b000; len = 3'd1; a = 32'h0; b = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = -1;
        for (int c = 3; c <= 12; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
        checks++; if (dc !== 5) begin errors++; $display("FAIL ignored_done_cycle got %0d exp 5", dc); end
        checks++; if (result !== 32'hF0F0_F0F0) begin errors++; $display("FAIL ignored_result got %h exp f0f0f0f0", result); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL ignored_flags got %b exp 0100", flags); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %0b exp 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_queued got %0b exp 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        @(negedge clk);
        op = 3'b000; len = 3'd4; a = 32'h0102_0304; b = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h exp 0", result); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL midrst_flags got %b exp 0000", flags); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d exp 0", state_dbg); end
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            saw_done = saw_done | done;
            @(negedge clk);
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %0b exp 0", saw_done); end
    endtask

`ifdef ALU_MP_SEQ_ABORT_EN
    task automatic test_abort();
        logic saw_done;
        int dc; logic [15:0] bm;
        drive_op(3'b000, 3'd2, 1'b0, 32'h0000_0011, 32'h0000_0022, dc, bm);
        @(negedge clk);
        op = 3'b010; len = 3'd4; a = 32'h0000_0001; b = 32'h0000_0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got %h exp 0", result); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state_dbg); end
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            saw_done = saw_done | done;
            @(negedge clk);
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0b exp 0", saw_done); end
    endtask
`endif

    // Watchdog: the tasks are individually bounded; this guards the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_sbc();
        test_sra();
        test_partial_len();
        test_xor_and_len0();
        test_len_clamp();
        test_start_ignored();
        test_reset_mid_run();
`ifdef ALU_MP_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
